// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Brings a PLL out of reset, waits for its LOCK to settle, qualifies it for a
//   continuous stable window and only then releases the reset of the logic
//   clocked by the PLL. Lock timeouts are retried; repeated timeouts latch a
//   fault that is cleared only by clear_fault_i. Loss of lock while running
//   restarts the whole sequence.
//
//   Optional feature: define PLL_SEQ_LOSS_COUNT_EN to build a saturating 8-bit
//   lock-loss event counter; without it lock_loss_count_o is tied to zero.
//
// Ports
//   referenceclk_i     reference clock (also the PLL input clock)
//   reset_ni           asynchronous active-low reset, released synchronously
//   pll_lock_i         raw PLL LOCK, asynchronous to referenceclk_i
//   clear_fault_i      single-cycle fault-clear request (FAULT state only)
//   pll_resetb_o       PLL RESETB, active-low
//   sys_reset_n_o      active-low reset for PLL-clocked logic
//   ready_o            high while the PLL is qualified (RUN)
//   fault_o            high after retry exhaustion
//   lock_loss_count_o  lock-loss events since reset (saturating)
module pll_lock_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       referenceclk_i,
  input  logic       reset_ni,
  input  logic       pll_lock_i,
  input  logic       clear_fault_i,
  output logic       pll_resetb_o,
  output logic       sys_reset_n_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [7:0] lock_loss_count_o
);

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRun,
    StFault
  } state_e;

  // Counter is zero on the first cycle of a state, so a state lasting N cycles
  // exits when the counter reads N-1.
  localparam logic [15:0] RstLast     = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] StableLast  = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  MaxRetries  = 4'(MAX_RETRIES);

  // Two-flop synchronizer; only lock_s_q is seen by the FSM.
  logic sync1_q;
  logic lock_s_q;

  always_ff @(posedge referenceclk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock_i;
      lock_s_q <= sync1_q;
    end
  end

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [3:0]  retry_q;
  logic        pll_resetb_q;
  logic        sys_reset_n_q;
  logic        ready_q;
  logic        fault_q;

  // Output pattern {pll_resetb, sys_reset_n, ready, fault} for a given state.
  // Outputs are loaded from the destination state on every transition so they
  // change on the same edge as the state register.
  function automatic logic [3:0] state_outs(input state_e s);
    logic [3:0] o;
    case (s)
      StWaitLock, StStable: o = 4'b1000;
      StRun:                o = 4'b1110;
      StFault:              o = 4'b0001;
      default:              o = 4'b0000;
    endcase
    return o;
  endfunction

  always_ff @(posedge referenceclk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= StPllRst;
      cnt_q         <= '0;
      retry_q       <= '0;
      pll_resetb_q  <= 1'b0;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StPllRst: begin
          if (cnt_q == RstLast) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
            {pll_resetb_q, sys_reset_n_q, ready_q, fault_q} <= state_outs(StWaitLock);
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        StWaitLock: begin
          // Lock is checked first so it wins over a coincident timeout.
          if (lock_s_q) begin
            state_q <= StStable;
            cnt_q   <= '0;
            {pll_resetb_q, sys_reset_n_q, ready_q, fault_q} <= state_outs(StStable);
          end else if (cnt_q == TimeoutLast) begin
            retry_q <= retry_q + 4'd1;
            cnt_q   <= '0;
            if (retry_q + 4'd1 == MaxRetries) begin
              state_q <= StFault;
              {pll_resetb_q, sys_reset_n_q, ready_q, fault_q} <= state_outs(StFault);
            end else begin
              state_q <= StPllRst;
              {pll_resetb_q, sys_reset_n_q, ready_q, fault_q} <= state_outs(StPllRst);
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        StStable: begin
          if (!lock_s_q) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
            {pll_resetb_q, sys_reset_n_q, ready_q, fault_q} <= state_outs(StWaitLock);
          end else if (cnt_q == StableLast) begin
            state_q <= StRun;
            cnt_q   <= '0;
            retry_q <= '0;
            {pll_resetb_q, sys_reset_n_q, ready_q, fault_q} <= state_outs(StRun);
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        StRun: begin
          if (!lock_s_q) begin
            state_q <= StPllRst;
            cnt_q   <= '0;
            {pll_resetb_q, sys_reset_n_q, ready_q, fault_q} <= state_outs(StPllRst);
          end
        end

        StFault: begin
          if (clear_fault_i) begin
            state_q <= StPllRst;
            cnt_q   <= '0;
            retry_q <= '0;
            {pll_resetb_q, sys_reset_n_q, ready_q, fault_q} <= state_outs(StPllRst);
          end
        end

        default: begin
          state_q <= StPllRst;
          cnt_q   <= '0;
          {pll_resetb_q, sys_reset_n_q, ready_q, fault_q} <= state_outs(StPllRst);
        end
      endcase
    end
  end

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q;

  // Counts exactly the RUN -> PLL_RST transitions, on the same edge.
  always_ff @(posedge referenceclk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      loss_cnt_q <= '0;
    end else if (state_q == StRun && !lock_s_q && loss_cnt_q != 8'hFF) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign lock_loss_count_o = loss_cnt_q;
`else
  assign lock_loss_count_o = 8'd0;
`endif

  assign pll_resetb_o  = pll_resetb_q;
  assign sys_reset_n_o = sys_reset_n_q;
  assign ready_o       = ready_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer: nominal table, hand-written corner
// sequences and a randomized run, all compared against a reference model.
module tb_pll_lock_sequencer;

  localparam int RstN = 4;
  localparam int StN  = 8;
  localparam int ToN  = 20;
  localparam int MrN  = 2;

`ifdef PLL_SEQ_LOSS_COUNT_EN
  localparam bit LossEn = 1'b1;
`else
  localparam bit LossEn = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       pll_lock;
  logic       clear_fault;
  logic       pll_resetb;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [7:0] loss_count;
  logic [11:0] dut_v;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES     (RstN),
    .LOCK_STABLE_CYCLES (StN),
    .LOCK_TIMEOUT_CYCLES(ToN),
    .MAX_RETRIES        (MrN)
  ) u_dut (
    .referenceclk_i   (clk),
    .reset_ni         (reset_n),
    .pll_lock_i       (pll_lock),
    .clear_fault_i    (clear_fault),
    .pll_resetb_o     (pll_resetb),
    .sys_reset_n_o    (sys_reset_n),
    .ready_o          (ready),
    .fault_o          (fault),
    .lock_loss_count_o(loss_count)
  );

  assign dut_v = {pll_resetb, sys_reset_n, ready, fault, loss_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus the 1-based cycle number within that phase.
  localparam int PhRst = 0, PhWait = 1, PhStab = 2, PhRun = 3, PhFlt = 4;
  int ph, age, retries, losses;
  int hist[$];  // raw lock samples; the FSM acts on the one taken two edges ago

  task automatic model_reset();
    ph = PhRst;
    age = 1;
    retries = 0;
    losses = 0;
    hist = {};
    hist.push_back(0);
    hist.push_back(0);
  endtask

  task automatic model_edge(input logic lk_raw, input logic clr);
    int lk;
    lk = hist.pop_front();
    hist.push_back(int'(lk_raw));
    case (ph)
      PhRst: if (age == RstN) begin ph = PhWait; age = 1; end else age++;
      PhWait: begin
        if (lk != 0) begin
          ph = PhStab; age = 1;
        end else if (age == ToN) begin
          retries++;
          ph = (retries == MrN) ? PhFlt : PhRst;
          age = 1;
        end else age++;
      end
      PhStab: begin
        if (lk == 0) begin ph = PhWait; age = 1; end
        else if (age == StN) begin ph = PhRun; age = 1; retries = 0; end
        else age++;
      end
      PhRun: if (lk == 0) begin ph = PhRst; age = 1; if (losses < 255) losses++; end
      PhFlt: if (clr) begin ph = PhRst; age = 1; retries = 0; end
      default: ph = PhRst;
    endcase
  endtask

  function automatic logic [11:0] model_v();
    logic [7:0] l8;
    l8 = LossEn ? 8'(losses) : 8'd0;
    return {ph == PhWait || ph == PhStab || ph == PhRun, ph == PhRun, ph == PhRun,
            ph == PhFlt, l8};
  endfunction

  task automatic step(input string tag);
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge(pll_lock, clear_fault);
    #1;
    check(tag, dut_v, model_v());
  endtask

  // Assert reset mid-cycle, check outputs before the next edge, release after an edge.
  task automatic do_reset(input string name);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check(name, dut_v, 12'h000);
    step("held_reset");
    reset_n = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 40) begin
      step(name);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL %s: ready got 0 expected 1 within 40 cycles", name);
    end
  endtask

  typedef struct {
    int         n;
    logic       lock;
    logic       clr;
    logic [3:0] exp;  // {pll_resetb, sys_reset_n, ready, fault}
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Edge numbers count from reset release; lock is first sampled at edge 10.
    tbl[0]  = '{3,  1'b0, 1'b0, 4'b0000};  // PLL_RST
    tbl[1]  = '{6,  1'b0, 1'b0, 4'b1000};  // WAIT_LOCK
    tbl[2]  = '{10, 1'b1, 1'b0, 4'b1000};  // sync + STABLE
    tbl[3]  = '{4,  1'b1, 1'b0, 4'b1110};  // RUN from edge 20
    tbl[4]  = '{2,  1'b0, 1'b0, 4'b1110};  // drop seen two edges later
    tbl[5]  = '{1,  1'b1, 1'b0, 4'b0000};  // RUN -> PLL_RST
    tbl[6]  = '{3,  1'b1, 1'b0, 4'b0000};
    tbl[7]  = '{9,  1'b1, 1'b0, 4'b1000};  // 1 WAIT + 8 STABLE
    tbl[8]  = '{1,  1'b1, 1'b0, 4'b1110};
    tbl[9]  = '{1,  1'b1, 1'b1, 4'b1110};  // clear_fault ignored in RUN
    tbl[10] = '{1,  1'b1, 1'b0, 4'b1110};

    reset_n = 1'b0;
    pll_lock = 1'b0;
    clear_fault = 1'b0;
    model_reset();
    #2;
    check("reset_state", dut_v, 12'h000);
    step("held_reset");
    step("held_reset");
    reset_n = 1'b1;

    // Nominal start and one lock loss in RUN.
    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        pll_lock = tbl[r].lock;
        clear_fault = tbl[r].clr;
        step("nominal_model");
        check($sformatf("nominal_row%0d", r), {8'd0, dut_v[11:8]}, {8'd0, tbl[r].exp});
      end
    end
    clear_fault = 1'b0;
    check("loss_after_one", {4'd0, loss_count}, LossEn ? 12'd1 : 12'd0);

    do_reset("async_run");

    // One-cycle lock glitch during STABLE restarts the full qualification.
    for (int i = 1; i <= 18; i++) begin
      pll_lock = (i != 7);
      step("glitch");
      if (i == 9)  check("glitch_back_to_wait", {11'd0, pll_resetb}, 12'd1);
      if (i == 13) check("glitch_ready13", {11'd0, ready}, 12'd0);
      if (i == 17) check("glitch_ready17", {11'd0, ready}, 12'd0);
      if (i == 18) check("glitch_ready18", {11'd0, ready}, 12'd1);
    end

    do_reset("async_run2");
    for (int i = 1; i <= 7; i++) begin
      pll_lock = 1'b1;
      step("to_stable");
    end
    do_reset("async_stable");

    // Lock never arrives: two timeouts end in FAULT.
    for (int i = 1; i <= 52; i++) begin
      pll_lock = 1'b0;
      step("timeout");
      if (i == 23) check("timeout1_wait", {10'd0, pll_resetb, fault}, 12'b10);
      if (i == 24) check("timeout1_rst", {10'd0, pll_resetb, fault}, 12'b00);
      if (i == 47) check("timeout2_wait", {10'd0, pll_resetb, fault}, 12'b10);
      if (i == 48) check("fault_set", {10'd0, pll_resetb, fault}, 12'b01);
      if (i == 52) check("fault_hold", {10'd0, pll_resetb, fault}, 12'b01);
    end

    do_reset("async_fault");

    // Lock arrives exactly on the timeout cycle: lock wins, no retry consumed.
    for (int i = 1; i <= 80; i++) begin
      pll_lock = (i == 22);
      clear_fault = (i == 76);
      step("simul");
      if (i == 24) check("simul_lock_wins", {10'd0, pll_resetb, fault}, 12'b10);
      if (i == 44) check("simul_wait", {10'd0, pll_resetb, fault}, 12'b10);
      if (i == 45) check("retry_not_bumped", {10'd0, pll_resetb, fault}, 12'b00);
      if (i == 68) check("pre_fault", {10'd0, pll_resetb, fault}, 12'b10);
      if (i == 69) check("fault_after_two", {10'd0, pll_resetb, fault}, 12'b01);
      if (i == 75) check("fault_held", {10'd0, pll_resetb, fault}, 12'b01);
      if (i == 76) check("clear_fault", {10'd0, pll_resetb, fault}, 12'b00);
      if (i == 79) check("clear_rst4", {10'd0, pll_resetb, fault}, 12'b00);
      if (i == 80) check("clear_wait", {10'd0, pll_resetb, fault}, 12'b10);
    end
    clear_fault = 1'b0;

    do_reset("async_pre_loss");

    // Repeated lock loss in RUN; counter saturates.
    pll_lock = 1'b1;
    for (int k = 0; k < 300; k++) begin
      wait_ready("loss_wait");
      if (!ready) break;
      if (k == 3) check("loss_count3", {4'd0, loss_count}, LossEn ? 12'd3 : 12'd0);
      pll_lock = 1'b0;
      step("loss_drop");
      pll_lock = 1'b1;
    end
    wait_ready("loss_wait_end");
    check("loss_count_sat", {4'd0, loss_count}, LossEn ? 12'd255 : 12'd0);

    do_reset("async_pre_random");

    // Randomized bursts of lock, sporadic clears and resets.
    begin
      int hold = 0;
      logic lvl = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        if (hold == 0) begin
          lvl = ($urandom_range(0, 3) != 0);
          hold = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 25));
        end
        hold--;
        pll_lock = lvl;
        clear_fault = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 499) == 0) do_reset("rand_reset");
        step("random");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have one clock, REFERENCECLK, and reset RESET, asynchronous and active-low.
REQ-002 Parameter PLL_RST_CYCLES, default 16, SHALL set the PLL_RESETB low-hold duration in cycles (1..65535).
REQ-003 Parameter LOCK_STABLE_CYCLES, default 1024, SHALL set the continuous-lock qualification time in cycles (1..65535).
REQ-004 Parameter LOCK_TIMEOUT_CYCLES, default 65535, SHALL set the maximum wait for lock per attempt in cycles (1..65535).
REQ-005 Parameter MAX_RETRIES, default 3, SHALL set the number of consecutive timeouts that trigger FAULT (1..15).
REQ-006 Ports SHALL be as follows:
- REFERENCECLK  in  1  16 MHz reference clock (same net as PLL input)
- RESET  in  1  async active-low reset
- PLL_LOCK  in  1  raw PLL LOCK, asynchronous
- CLEAR_FAULT  in  1  single-cycle fault-clear request
- PLL_RESETB  out  1  drives PLL RESETB, active-low
- SYS_RESET_N  out  1  active-low reset for PLL-clocked logic
- READY  out  1  high while PLL is qualified
- FAULT  out  1  high after retry exhaustion
- LOCK_LOSS_COUNT  out  8  lock-loss events since RESET

Function
REQ-007 PLL_LOCK SHALL pass through a 2-flop synchronizer; lock_s is the second stage, and the FSM uses only lock_s.
REQ-008 The FSM SHALL have states PLL_RST, WAIT_LOCK, STABLE, RUN and FAULT, with a 16-bit cycle counter cleared on every state entry.
REQ-009 All outputs SHALL be registered and SHALL change on the same edge as the state register.
REQ-010 In PLL_RST, PLL_RESETB=0 and SYS_RESET_N=0; the FSM SHALL stay exactly PLL_RST_CYCLES cycles, then enter WAIT_LOCK.
REQ-011 In WAIT_LOCK, PLL_RESETB=1 and SYS_RESET_N=0.
- lock_s=1: go to STABLE.
- No lock after LOCK_TIMEOUT_CYCLES cycles: increment retry_cnt (4-bit), then go to FAULT if the new value equals MAX_RETRIES, else to PLL_RST.
REQ-012 If lock_s rises on the same cycle as the timeout in WAIT_LOCK, lock SHALL win: no retry increment, go to STABLE.
REQ-013 In STABLE, PLL_RESETB=1 and SYS_RESET_N=0.
- lock_s=0 at any cycle: return to WAIT_LOCK with the timeout restarted.
- lock_s=1 for LOCK_STABLE_CYCLES consecutive cycles: go to RUN.
REQ-014 Entering RUN SHALL clear retry_cnt.
REQ-015 In RUN, SYS_RESET_N=1 and READY=1.
- lock_s=0: go to PLL_RST and record one lock-loss event.
- SYS_RESET_N and READY SHALL drop on that same edge.
REQ-016 In FAULT, PLL_RESETB=0, SYS_RESET_N=0 and FAULT=1; CLEAR_FAULT=1 SHALL clear retry_cnt and go to PLL_RST.
REQ-017 CLEAR_FAULT SHALL be ignored in all states other than FAULT.
REQ-018 READY SHALL be high only in RUN, and FAULT SHALL be high only in the FAULT state.
REQ-019 From the first REFERENCECLK edge sampling PLL_LOCK=1 in WAIT_LOCK, SYS_RESET_N SHALL rise after exactly 2+LOCK_STABLE_CYCLES edges, provided lock holds.

Reset
REQ-020 While RESET=0, the block SHALL drive these values immediately, independent of the clock:
- state=PLL_RST, counter=0, retry_cnt=0, synchronizer=0
- PLL_RESETB=0, SYS_RESET_N=0, READY=0, FAULT=0, LOCK_LOSS_COUNT=0
REQ-021 RESET deassertion SHALL be synchronous to REFERENCECLK (board reset synchronizer); the first cycle after deassertion is PLL_RST cycle 1.
REQ-022 RESET asserted mid-operation in any state SHALL abort that state with no partial update of LOCK_LOSS_COUNT.

Configuration
REQ-023 With macro PLL_SEQ_LOSS_COUNT_EN defined, LOCK_LOSS_COUNT SHALL increment by 1 on each RUN-to-PLL_RST transition and saturate at 255.
REQ-024 Without PLL_SEQ_LOSS_COUNT_EN, LOCK_LOSS_COUNT SHALL be constant 0 and no counter register shall be synthesized; all other behaviour is identical.

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=20, MAX_RETRIES=2)
REQ-025 Nominal start: release RESET with PLL_LOCK high from cycle 10 -> PLL_RESETB low 4 cycles, then 1; SYS_RESET_N=1 and READY=1 exactly 10 edges after lock first sampled.
REQ-026 Lock glitch: drop PLL_LOCK for 1 cycle during STABLE -> return to WAIT_LOCK, READY stays 0, and a full 8-cycle qualification restarts.
REQ-027 Timeout/fault: hold PLL_LOCK=0 -> two PLL_RST pulses, FAULT=1 after the second 20-cycle timeout, PLL_RESETB=0 held.
- Then pulse CLEAR_FAULT -> FAULT=0 and a new 4-cycle PLL_RST.
REQ-028 Lock loss in RUN: drop PLL_LOCK 3 times -> SYS_RESET_N falls each time, LOCK_LOSS_COUNT=3 with the macro, 0 without.
- Also force 300 losses -> LOCK_LOSS_COUNT=255.
REQ-029 Async reset: assert RESET mid-STABLE and mid-RUN -> all outputs reach reset values before the next clock edge.
REQ-030 Simultaneity: raise PLL_LOCK so lock_s=1 on timeout cycle 20 -> STABLE entered, retry_cnt unchanged.
